// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter sharing one UART transmitter among NUM_REQ
//            byte producers; launches each byte and tracks busy to completion.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            ack,
   output logic [NUM_REQ-1:0]            done,
   output logic                          timeout_err,
   output logic                          uart_start,
   output logic [DATA_WIDTH-1:0]         uart_data,
   input  logic                          uart_busy,
   output logic                          active,
   output logic [$clog2(NUM_REQ)-1:0]    grant_idx
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
   localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   last;
   logic [CNT_W-1:0]   cnt;
   logic               win_valid;
   logic [IDX_W-1:0]   win_idx;

   // Search starts one past the previous owner, so it is always the lowest priority.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!win_valid && req[(int'(last) + k) % NUM_REQ]) begin
            win_valid = 1'b1;
            win_idx   = IDX_W'((int'(last) + k) % NUM_REQ);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last        <= IDX_W'(NUM_REQ - 1);
         grant_idx   <= '0;
         uart_data   <= '0;
         cnt         <= '0;
         ack         <= '0;
         done        <= '0;
         timeout_err <= 1'b0;
         uart_start  <= 1'b0;
         active      <= 1'b0;
      end else begin
         ack         <= '0;
         done        <= '0;
         timeout_err <= 1'b0;
         uart_start  <= 1'b0;
         case (state)
            IDLE: begin
               // The cycle carrying a done pulse is a mandatory idle gap before the next grant.
               if (win_valid && ~|done) begin
                  grant_idx  <= win_idx;
                  last       <= win_idx;
                  uart_data  <= req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                  uart_start <= 1'b1;
                  ack        <= ONE_HOT_0 << win_idx;
                  active     <= 1'b1;
                  state      <= START;
               end
            end
            START: begin
               cnt   <= '0;
               state <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (uart_busy) begin
                  state <= WAIT_DONE;
               end else if (cnt == CNT_W'(BUSY_TIMEOUT - 2)) begin
                  timeout_err <= 1'b1;
                  active      <= 1'b0;
                  state       <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!uart_busy) begin
                  done   <= ONE_HOT_0 << grant_idx;
                  active <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               active <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed self-checking bench for uart_tx_arbiter with a UART busy stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

   localparam int NR    = 4;
   localparam int DW    = 8;
   localparam int BT    = 16;
   localparam int FRAME = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [NR-1:0] req;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0] ack;
   logic [NR-1:0] done;
   logic          timeout_err;
   logic          uart_start;
   logic [DW-1:0] uart_data;
   logic          uart_busy;
   logic          active;
   logic [1:0]    grant_idx;

   logic          stub_en;
   int            bcnt;
   int            total = 0;
   int            bad   = 0;
   logic          ack_seen;
   logic          done_seen;
   int            n;

   uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BUSY_TIMEOUT(BT)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .done(done),
      .timeout_err(timeout_err), .uart_start(uart_start), .uart_data(uart_data),
      .uart_busy(uart_busy), .active(active), .grant_idx(grant_idx)
   );

   always #5 clk = ~clk;

   // UART stand-in: busy rises on the edge that samples start and stays high FRAME cycles.
   always @(posedge clk or posedge rst) begin
      if (rst)                       bcnt <= 0;
      else if (bcnt != 0)            bcnt <= bcnt - 1;
      else if (stub_en && uart_start) bcnt <= FRAME;
   end
   assign uart_busy = (bcnt != 0);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (|ack)  ack_seen  = 1'b1;
      if (|done) done_seen = 1'b1;
      if (uart_start) check("start_vs_busy", {31'b0, uart_busy}, 32'd0);
   endtask

   function automatic logic probe(input int sel);
      case (sel)
         0:       probe = |ack;
         1:       probe = |done;
         2:       probe = timeout_err;
         default: probe = uart_busy;
      endcase
   endfunction

   task automatic wait_for(input int sel, input int lim, output int cnt);
      cnt = 0;
      while (!probe(sel) && cnt < lim) begin
         tick();
         cnt++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=hang expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req = '0; req_data = '0; stub_en = 1'b1;
      ack_seen = 1'b0; done_seen = 1'b0;
      tick();
      tick();
      check("rst_ack",       {28'b0, ack}, 32'd0);
      check("rst_done",      {28'b0, done}, 32'd0);
      check("rst_timeout",   {31'b0, timeout_err}, 32'd0);
      check("rst_start",     {31'b0, uart_start}, 32'd0);
      check("rst_active",    {31'b0, active}, 32'd0);
      check("rst_data",      {24'b0, uart_data}, 32'd0);
      check("rst_grant_idx", {30'b0, grant_idx}, 32'd0);
      rst = 1'b0;

      // Single requester
      req_data = 32'h000000A5; req = 4'b0001;
      tick();
      check("single_ack",    {28'b0, ack}, 32'h1);
      check("single_start",  {31'b0, uart_start}, 32'd1);
      check("single_data",   {24'b0, uart_data}, 32'hA5);
      check("single_active", {31'b0, active}, 32'd1);
      req = '0;
      tick();
      check("single_start_off", {31'b0, uart_start}, 32'd0);
      check("single_ack_off",   {28'b0, ack}, 32'd0);
      wait_for(1, 30, n);
      check("single_done_lat", n, 32'd6);
      check("single_done",     {28'b0, done}, 32'h1);
      check("single_busy_low", {31'b0, uart_busy}, 32'd0);
      tick();
      check("single_done_off", {28'b0, done}, 32'd0);
      check("single_idle",     {31'b0, active}, 32'd0);

      // All four requesters held high
      do_reset();
      req_data = 32'h44332211; req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         wait_for(0, 30, n);
         if (g > 0) check("rr_gap", n, 32'd8);
         check("rr_ack",  {28'b0, ack}, 32'h1 << (g % 4));
         check("rr_idx",  {30'b0, grant_idx}, g % 4);
         check("rr_data", {24'b0, uart_data}, 32'h11 * ((g % 4) + 1));
         if (g == 4) req = '0;
         tick();
      end
      wait_for(1, 30, n);
      check("rr_last_done", {28'b0, done}, 32'h1);
      tick();

      // Rotation fairness
      do_reset();
      req_data = 32'hD33CB1A0; req = 4'b0100;
      for (int g = 0; g < 3; g++) begin
         wait_for(0, 30, n);
         check("hold2_ack",  {28'b0, ack}, 32'h4);
         check("hold2_data", {24'b0, uart_data}, 32'h3C);
         if (g == 2) req = 4'b1001;
         tick();
      end
      wait_for(0, 30, n);
      check("fair_first3",   {28'b0, ack}, 32'h8);
      check("fair_data3",    {24'b0, uart_data}, 32'hD3);
      tick();
      wait_for(0, 30, n);
      check("fair_then0",    {28'b0, ack}, 32'h1);
      check("fair_data0",    {24'b0, uart_data}, 32'hA0);
      tick();
      wait_for(0, 30, n);
      check("fair_back3",    {28'b0, ack}, 32'h8);
      req = '0;
      tick();
      wait_for(1, 30, n);
      tick();

      // Timeout with busy stuck low
      do_reset();
      stub_en = 1'b0;
      req_data = 32'h00006600; req = 4'b0010;
      wait_for(0, 30, n);
      check("to_ack", {28'b0, ack}, 32'h2);
      req = '0;
      done_seen = 1'b0;
      tick();
      wait_for(2, 40, n);
      check("to_latency",  n + 1, BT);
      check("to_pulse",    {31'b0, timeout_err}, 32'd1);
      check("to_idle",     {31'b0, active}, 32'd0);
      tick();
      check("to_one_cycle", {31'b0, timeout_err}, 32'd0);
      check("to_no_done",   {31'b0, done_seen}, 32'd0);
      stub_en = 1'b1;

      // Reset during WAIT_DONE
      req_data = 32'h000000FF; req = 4'b0001;
      wait_for(0, 30, n);
      check("mid_ack",  {28'b0, ack}, 32'h1);
      check("mid_data", {24'b0, uart_data}, 32'hFF);
      req = '0;
      tick(); tick(); tick();
      check("mid_busy",   {31'b0, uart_busy}, 32'd1);
      check("mid_active", {31'b0, active}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_outs", {13'b0, ack, done, timeout_err, uart_start, active, uart_data, grant_idx}, 32'd0);
      done_seen = 1'b0;
      tick(); tick();
      rst = 1'b0;
      req_data = 32'h00000042; req = 4'b0001;
      wait_for(0, 30, n);
      check("mid_regrant_fast", {31'b0, (n <= 2)}, 32'd1);
      check("mid_regrant_ack",  {28'b0, ack}, 32'h1);
      check("mid_no_done",      {31'b0, done_seen}, 32'd0);
      req = '0;
      tick();
      wait_for(1, 30, n);
      tick();

      // Late request while another transfer is in flight
      req_data = 32'h0077005A; req = 4'b0001;
      wait_for(0, 30, n);
      check("late_first_ack", {28'b0, ack}, 32'h1);
      req = '0;
      wait_for(3, 30, n);
      req = 4'b0100;
      ack_seen = 1'b0;
      wait_for(1, 30, n);
      check("late_done",   {28'b0, done}, 32'h1);
      check("late_no_ack", {31'b0, ack_seen}, 32'd0);
      wait_for(0, 30, n);
      check("late_ack_gap", n, 32'd2);
      check("late_ack",     {28'b0, ack}, 32'h4);
      check("late_data",    {24'b0, uart_data}, 32'h77);
      req = '0;
      tick();
      wait_for(1, 30, n);
      check("late_done2", {28'b0, done}, 32'h4);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
